updown_mod_counter: RTL

//  Parametrised up/down counter with programmable modulus, synchronous load, hold and

---
 rtl/counter_pkg.sv | 25 ++
 rtl/bcd_conv_seq.sv | 100 ++++++++++
 rtl/updown_mod_counter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for updown_mod_counter and its optional BCD converter.
//   conv_state_e     : converter state encoding (IDLE / CONV / DONE)
//   bcd_digits()     : number of decimal digits needed for a WIDTH-bit value
//   clamp_to_modulus : saturate a load value into the legal count range
// ---------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        CONV_IDLE = 2'd0,
        CONV_RUN  = 2'd1,
        CONV_DONE = 2'd2
    } conv_state_e;

    // ceil(width * log10(2)), using log10(2) ~= 0.30103 in fixed point.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

    function automatic int clamp_to_modulus(input int value, input int modulus);
        return (value >= modulus) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/bcd_conv_seq.sv
// ---------------------------------------------------------------------------
// bcd_conv_seq
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clk).
// Built only when COUNTER_BCD_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_ena      : clock enable; low freezes all state
//   i_start    : request a conversion of i_bin (accepted in IDLE or DONE)
//   i_bin      : binary value, sampled on the accepting edge
//   o_busy     : conversion in progress (CONV state)
//   o_done     : one-state pulse; o_bcd holds the finished result
//   o_bcd      : packed BCD digits, least-significant digit in [3:0]
// ---------------------------------------------------------------------------
`ifdef COUNTER_BCD_EN
module bcd_conv_seq
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_ena,
    input  logic                               i_start,
    input  logic [WIDTH-1:0]                   i_bin,
    output logic                               o_busy,
    output logic                               o_done,
    output logic [4*bcd_digits(WIDTH)-1:0]     o_bcd
);

    localparam int ND    = bcd_digits(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    conv_state_e       r_state;
    conv_state_e       w_state_nxt;
    logic [WIDTH-1:0]  r_bin;
    logic [4*ND-1:0]   r_acc;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [4*ND-1:0]   w_adj;
    logic              w_accept;
    logic              w_last_bit;

    assign w_last_bit = (r_bit_cnt == CNT_W'(WIDTH - 1));
    // DONE may chain straight into a new conversion, which keeps the
    // worst-case refresh period at WIDTH+1 clocks.
    assign w_accept   = i_start && (r_state != CONV_RUN);

    // Add 3 to every digit >= 5 before the shift so it carries correctly.
    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < ND; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CONV_IDLE: if (i_start) w_state_nxt = CONV_RUN;
            CONV_RUN:  if (w_last_bit) w_state_nxt = CONV_DONE;
            CONV_DONE: w_state_nxt = i_start ? CONV_RUN : CONV_IDLE;
            default:   w_state_nxt = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CONV_IDLE;
        end else if (i_ena) begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the datapath registers are reset as well, so o_bcd reads zero
    // straight out of reset instead of stale or unknown digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_acc     <= '0;
            r_bit_cnt <= '0;
        end else if (i_ena) begin
            if (w_accept) begin
                r_bin     <= i_bin;
                r_acc     <= '0;
                r_bit_cnt <= '0;
            end else if (r_state == CONV_RUN) begin
                r_bin     <= r_bin << 1;
                r_acc     <= {w_adj[4*ND-2:0], r_bin[WIDTH-1]};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy = (r_state == CONV_RUN);
    assign o_done = (r_state == CONV_DONE);
    assign o_bcd  = r_acc;

endmodule
`endif

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
// Up/down counter with programmable modulus, synchronous load (clamped),
// hold, registered terminal-count pulse and sticky wrap flag.
// Optional macro COUNTER_BCD_EN adds a sequential binary-to-BCD converter
// (bcd_conv_seq) and the bcd_out / bcd_valid ports.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   ena             : global enable; low freezes all state
//   up, down        : step requests (one step per clk; both/neither = no step)
//   hold            : freeze count
//   load, load_val  : synchronous load, clamped to MODULUS-1
//   count           : current count, always 0..MODULUS-1
//   tc              : one-cycle pulse in the cycle a wrapped value appears
//   wrapped         : sticky wrap flag, cleared by reset or load
//   bcd_out         : [COUNTER_BCD_EN] BCD digits of the last converted count
//   bcd_valid       : [COUNTER_BCD_EN] bcd_out matches the current count
// ---------------------------------------------------------------------------
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 256,
    parameter int RESET_VAL = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ena,
    input  logic                            up,
    input  logic                            down,
    input  logic                            hold,
    input  logic                            load,
    input  logic [WIDTH-1:0]                load_val,
    output logic [WIDTH-1:0]                count,
    output logic                            tc,
    output logic                            wrapped
`ifdef COUNTER_BCD_EN
    ,
    output logic [4*bcd_digits(WIDTH)-1:0]  bcd_out,
    output logic                            bcd_valid
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_wrapped_nxt;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_clamped = WIDTH'(clamp_to_modulus(int'(load_val), MODULUS));

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_count_nxt   = r_count;
        w_tc_nxt      = 1'b0;
        w_wrapped_nxt = r_wrapped;
        if (load) begin
            w_count_nxt   = w_load_clamped;
            w_wrapped_nxt = 1'b0;
        end else if (!hold && up && !down) begin
            // Explicit compare even when MODULUS == 2**WIDTH, so tc still fires.
            if (r_count == MAX_VAL) begin
                w_count_nxt   = '0;
                w_tc_nxt      = 1'b1;
                w_wrapped_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + WIDTH'(1);
            end
        end else if (!hold && down && !up) begin
            if (r_count == '0) begin
                w_count_nxt   = MAX_VAL;
                w_tc_nxt      = 1'b1;
                w_wrapped_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count - WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= RST_VAL;
            r_tc      <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (ena) begin
            r_count   <= w_count_nxt;
            r_tc      <= w_tc_nxt;
            r_wrapped <= w_wrapped_nxt;
        end else begin
            // A pulse must not stretch while the counter is frozen.
            r_tc <= 1'b0;
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign wrapped = r_wrapped;

`ifdef COUNTER_BCD_EN
    localparam int ND = bcd_digits(WIDTH);

    logic             w_conv_busy;
    logic             w_conv_done;
    logic             w_conv_start;
    logic [4*ND-1:0]  w_conv_bcd;
    logic [WIDTH-1:0] r_snap;
    logic             r_snap_valid;
    logic [4*ND-1:0]  r_bcd_out;
    logic             r_bcd_valid;

    // r_snap is the value handed to the converter; r_snap_valid forces one
    // conversion after reset even when the count equals the reset snapshot.
    assign w_conv_start = !w_conv_busy && (!r_snap_valid || (r_count != r_snap));

    bcd_conv_seq #(
        .WIDTH (WIDTH)
    ) u_bcd_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (ena),
        .i_start (w_conv_start),
        .i_bin   (r_count),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
            r_bcd_out    <= '0;
            r_bcd_valid  <= 1'b0;
        end else if (ena) begin
            if (w_conv_start) begin
                r_snap       <= r_count;
                r_snap_valid <= 1'b1;
            end
            if (w_conv_done) begin
                r_bcd_out   <= w_conv_bcd;
                r_bcd_valid <= (r_snap == r_count);
            end else begin
                r_bcd_valid <= r_bcd_valid && (r_snap == r_count);
            end
        end
    end

    assign bcd_out   = r_bcd_out;
    assign bcd_valid = r_bcd_valid;
`endif

endmodule
